message_scheduler: RTL and testbench
====================================

MESSAGE_SCHEDULER -- requirements
Module: message_scheduler

Interface
REQ-001 The block SHALL be clocked by axi_aclk and reset by reset (synchronous, active-high).
REQ-002 Ports SHALL be, clock and reset first:
- axi_aclk  in  1  clock
- reset  in  1  sync active-high reset
- sha_type  in  2  bit1=1: SHA-384/512 (64-bit words, 80 rounds); bit1=0: SHA-224/256 (32-bit words, 64 rounds)
- en  in  1  start enable from scheduler
- s_axis_tdata  in  64  padded message word; 32-bit mode uses [31:0]
- s_axis_tvalid  in  1  input word valid
- s_axis_tready  out  1  input accept
- s_axis_tlast  in  1  word 15 of final block
- m_axis_tdata  out  64  W_t to hash compute unit
- m_axis_tvalid  out  1  W_t valid
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  last W_t of final block
- err  out  1  one-cycle protocol-error pulse
REQ-003 Parameters SHALL be DATA_WIDTH (default 64, word width) and BLOCK_WORDS (default 16, input words per block).

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, EXPAND; a transfer SHALL occur on a cycle with tvalid and tready both high.
REQ-005 IDLE: s_axis_tready=0, m_axis_tvalid=0; on en=1, latch sha_type into mode_reg, clear t, enter LOAD next cycle.
REQ-006 LOAD (t=0..15): combinational pass-through, zero latency: m_axis_tdata=s_axis_tdata (upper 32 bits zeroed in 32-bit mode), m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
REQ-007 On each LOAD transfer, the word SHALL shift into a 16-entry window and t SHALL increment; the transfer at t=15 SHALL enter EXPAND and latch s_axis_tlast into last_blk.
REQ-008 EXPAND (t=16..N-1, N=80 when mode_reg[1]=1, else 64): s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=W_t=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16].
REQ-009 On each EXPAND transfer, W_t SHALL shift into the window and t SHALL increment.
REQ-010 At t=N-1, m_axis_tlast SHALL equal last_blk; m_axis_tlast SHALL be 0 at all other times.
REQ-011 The transfer at t=N-1 SHALL clear t; the next state SHALL be IDLE if last_blk=1, else LOAD.
REQ-012 64-bit mode: s0=ROTR1^ROTR8^SHR7, s1=ROTR19^ROTR61^SHR6, additions mod 2^64.
REQ-013 32-bit mode: s0=ROTR7^ROTR18^SHR3, s1=ROTR17^ROTR19^SHR10 on bits [31:0], additions mod 2^32, output [63:32]=0.
REQ-014 Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast, the window and t SHALL hold.
REQ-015 s_axis_tlast=1 on a LOAD transfer with t≠15 SHALL pulse err for one cycle and be otherwise ignored.
REQ-016 A change of sha_type from mode_reg in LOAD or EXPAND SHALL pulse err, abort to IDLE next cycle, and clear t and last_blk without emitting further words.
REQ-017 en is sampled only in IDLE; en deasserting mid-message SHALL have no effect.

Reset
REQ-018 Reset SHALL force state=IDLE, t=0, last_blk=0, mode_reg=0, err=0, and window contents to 0.
REQ-019 During reset and the first cycle after it, s_axis_tready, m_axis_tvalid and m_axis_tlast SHALL be 0.
REQ-020 Reset asserted mid-block SHALL abandon the block; no partial W_t SHALL be emitted afterwards.

Structure
REQ-021 Package sha2_pkg SHALL hold the sha_type encoding, BLOCK_WORDS=16, ROUNDS_256=64, ROUNDS_512=80 and the FSM state enum.
REQ-022 The small-sigma functions SHALL be one combinational sub-module, sigma_lower, instanced twice (s0 and s1) with a mode input.
REQ-023 The window SHALL be a shift register; the block SHALL use no RAM.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- SHA-256 "abc" padded block (W0=0x61626380, W15=0x18, tlast on W15) -> 64 outputs; W16=0x0000000061626380, W17=0x00000000000F0000, tlast only on t=63; then IDLE.
- SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> 80 outputs; W16=0x6162638000000000, W17=0x00030000000000C0, tlast on t=79.
- Two-block SHA-256 message (tlast only on block-2 W15) -> 128 outputs; no tlast at t=63 of block 1; direct LOAD re-entry.
- Random m_axis_tready toggling at 50% during the SHA-512 case -> same 80 words, data stable while stalled.
- sha_type flipped at t=30 -> err pulse, IDLE next cycle, no further m_axis_tvalid.
- tlast at t=5, then reset at t=20 -> err pulse at t=5; after reset all outputs 0, state IDLE.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: algorithm encoding, round counts,
// FSM states and the rotate helpers used by the small-sigma logic.
package sha2_pkg;

    typedef enum logic [1:0] {
        SHA_224 = 2'b00,
        SHA_256 = 2'b01,
        SHA_384 = 2'b10,
        SHA_512 = 2'b11
    } sha_type_e;

    localparam int BLOCK_WORDS = 16;
    localparam int ROUNDS_256  = 64;
    localparam int ROUNDS_512  = 80;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_e;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sigma_lower.sv
// SHA-2 small sigma (s0 or s1, chosen by IS_S1) for either word width.
// In 32-bit mode only x[31:0] is used and the upper half of y is zero.
module sigma_lower #(
    parameter bit IS_S1 = 1'b0
) (
    input  logic        wide,
    input  logic [63:0] x,
    output logic [63:0] y
);
    import sha2_pkg::*;

    logic [31:0] x32;
    assign x32 = x[31:0];

    always_comb begin
        y = '0;
        if (wide) begin
            if (IS_S1) y = rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
            else       y = rotr64(x, 1)  ^ rotr64(x, 8)  ^ (x >> 7);
        end else begin
            if (IS_S1) y = {32'd0, rotr32(x32, 17) ^ rotr32(x32, 19) ^ (x32 >> 10)};
            else       y = {32'd0, rotr32(x32, 7)  ^ rotr32(x32, 18) ^ (x32 >> 3)};
        end
    end

endmodule

// File: rtl/message_scheduler.sv
// SHA-2 message scheduler: passes the 16 block words straight through, then
// expands W16..W(N-1) from a 16-deep shift-register window.
module message_scheduler #(
    parameter int DATA_WIDTH  = 64,
    parameter int BLOCK_WORDS = sha2_pkg::BLOCK_WORDS
) (
    input  logic                  axi_aclk,
    input  logic                  reset,
    input  logic [1:0]            sha_type,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err
);
    import sha2_pkg::*;

    localparam logic [6:0] LAST_LOAD = 7'(BLOCK_WORDS - 1);

    state_e                state, next_state;
    logic [6:0]            t;
    logic [1:0]            mode_reg;
    logic                  last_blk;
    logic [DATA_WIDTH-1:0] window [BLOCK_WORDS];

    logic                  wide;
    logic                  mode_bad;
    logic                  xfer;
    logic [6:0]            last_t;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] s0_out, s1_out, w_sum, w_exp;

    assign wide     = mode_reg[1];
    assign mode_bad = (state != IDLE) && (sha_type != mode_reg);
    assign xfer     = m_axis_tvalid && m_axis_tready;
    assign last_t   = wide ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);

    assign load_word = wide ? s_axis_tdata : {{(DATA_WIDTH-32){1'b0}}, s_axis_tdata[31:0]};

    // window[BLOCK_WORDS-1] holds W[t-1]; window[0] holds W[t-16]
    sigma_lower #(.IS_S1(1'b0)) u_s0 (.wide(wide), .x(window[1]),             .y(s0_out));
    sigma_lower #(.IS_S1(1'b1)) u_s1 (.wide(wide), .x(window[BLOCK_WORDS-2]), .y(s1_out));

    assign w_sum = s1_out + window[BLOCK_WORDS-7] + s0_out + window[0];
    assign w_exp = wide ? w_sum : {{(DATA_WIDTH-32){1'b0}}, w_sum[31:0]};

    always_ff @(posedge axi_aclk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en) next_state = LOAD;
            end
            LOAD: begin
                if (mode_bad)                       next_state = IDLE;
                else if (xfer && t == LAST_LOAD)    next_state = EXPAND;
            end
            EXPAND: begin
                if (mode_bad)                       next_state = IDLE;
                else if (xfer && t == last_t)       next_state = last_blk ? IDLE : LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshakes are forced low while reset is held, and dropped in the cycle a mode change is seen
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            LOAD: begin
                m_axis_tdata = load_word;
                if (!mode_bad && !reset) begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                end
            end
            EXPAND: begin
                m_axis_tdata = w_exp;
                if (!mode_bad && !reset) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = last_blk && (t == last_t);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            t        <= '0;
            mode_reg <= '0;
            last_blk <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) window[i] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        mode_reg <= sha_type;
                        t        <= '0;
                        last_blk <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mode_bad) begin
                        err      <= 1'b1;
                        t        <= '0;
                        last_blk <= 1'b0;
                    end else if (xfer) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) window[i] <= window[i+1];
                        window[BLOCK_WORDS-1] <= load_word;
                        t <= t + 7'd1;
                        if (t == LAST_LOAD) last_blk <= s_axis_tlast;
                        else if (s_axis_tlast) err <= 1'b1;
                    end
                end
                EXPAND: begin
                    if (mode_bad) begin
                        err      <= 1'b1;
                        t        <= '0;
                        last_blk <= 1'b0;
                    end else if (xfer) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) window[i] <= window[i+1];
                        window[BLOCK_WORDS-1] <= w_exp;
                        t <= (t == last_t) ? 7'd0 : t + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_message_scheduler.sv
// Scoreboard bench for message_scheduler: a reference schedule is queued per block
// and compared against every W_t the DUT hands downstream.
module tb_message_scheduler;
    import sha2_pkg::*;

    logic        axi_aclk = 1'b0;
    logic        reset;
    logic [1:0]  sha_type;
    logic        en;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        err;

    always #5 axi_aclk = ~axi_aclk;

    message_scheduler #(.DATA_WIDTH(64), .BLOCK_WORDS(16)) dut (
        .axi_aclk      (axi_aclk),
        .reset         (reset),
        .sha_type      (sha_type),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .err           (err)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q [$];
    beat_t       obs_q [$];
    logic [63:0] msg [16];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          got_cnt, err_pulses, err_first_got, stall_events, stall_changes;

    function automatic logic [63:0] ref_s0(input logic [63:0] x, input bit wide);
        logic [31:0] v;
        v = x[31:0];
        if (wide) return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'd0, x[63:7]};
        return {32'd0, {v[6:0], v[31:7]} ^ {v[17:0], v[31:18]} ^ {3'd0, v[31:3]}};
    endfunction

    function automatic logic [63:0] ref_s1(input logic [63:0] x, input bit wide);
        logic [31:0] v;
        v = x[31:0];
        if (wide) return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'd0, x[63:6]};
        return {32'd0, {v[16:0], v[31:17]} ^ {v[18:0], v[31:19]} ^ {10'd0, v[31:10]}};
    endfunction

    task automatic push_expected(input bit wide, input bit final_blk);
        logic [63:0] w [80];
        beat_t       b;
        int          n;
        n = wide ? 80 : 64;
        for (int k = 0; k < n; k++) begin
            if (k < 16) w[k] = msg[k];
            else        w[k] = ref_s1(w[k-2], wide) + w[k-7] + ref_s0(w[k-15], wide) + w[k-16];
            if (!wide) w[k] = {32'd0, w[k][31:0]};
            b.data = w[k];
            b.last = final_blk && (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_msg(input logic [1:0] mode);
        sha_type = mode;
        en = 1'b1;
        @(posedge axi_aclk); #1;
        en = 1'b0;
    endtask

    // Feeds msg[] into the LOAD phase and collects W_t beats until n_out have been seen
    task automatic send_block(input bit final_blk, input int stall_pct, input int n_out,
                              input int bad_tlast_idx);
        int          i, cyc;
        bit          prev_stall;
        logic [63:0] held_d;
        logic        held_l;
        beat_t       b;
        i = 0; cyc = 0; prev_stall = 0; held_d = '0; held_l = 1'b0;
        got_cnt = 0; err_pulses = 0; err_first_got = -1; stall_events = 0; stall_changes = 0;
        while (got_cnt < n_out && cyc < 2000) begin
            s_axis_tvalid = (i < 16);
            if (i < 16) s_axis_tdata = msg[i];
            else        s_axis_tdata = '0;
            s_axis_tlast  = (i == 15 && final_blk) || (i == bad_tlast_idx);
            m_axis_tready = ($urandom_range(99) >= stall_pct);
            @(negedge axi_aclk);
            if (err) begin
                err_pulses++;
                if (err_first_got < 0) err_first_got = got_cnt;
            end
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l))
                stall_changes++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            if (prev_stall) begin
                stall_events++;
                held_d = m_axis_tdata;
                held_l = m_axis_tlast;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                b.data = m_axis_tdata;
                b.last = m_axis_tlast;
                obs_q.push_back(b);
                got_cnt++;
            end
            if (s_axis_tvalid && s_axis_tready) i++;
            @(posedge axi_aclk); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; sha_type = 2'b00;
        s_axis_tdata = 64'h1234; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        n_assert++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, err} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b, expected 0000", {s_axis_tready, m_axis_tvalid, m_axis_tlast, err});
        end
        n_assert++;
        if (dut.state !== IDLE) begin
            n_fail++; $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.state, IDLE);
        end
        @(posedge axi_aclk); #1;
        reset = 1'b0;
        @(negedge axi_aclk);
        n_assert++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_outputs: got %b, expected 000", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
        end
        @(posedge axi_aclk); #1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    endtask

    task automatic test_sha256_abc();
        beat_t o, e;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = '0;
        msg[0] = 64'h61626380; msg[15] = 64'h18;
        start_msg(2'b01);
        push_expected(1'b0, 1'b1);
        send_block(1'b1, 0, 64, -1);
        n_assert++;
        if (got_cnt !== 64) begin n_fail++; $display("[TB] FAIL abc256_count: got %0d, expected 64", got_cnt); end
        n_assert++;
        if (obs_q.size() < 18 || obs_q[16].data !== 64'h0000000061626380) begin
            n_fail++; $display("[TB] FAIL abc256_w16: got %h, expected 0000000061626380", obs_q[16].data);
        end
        n_assert++;
        if (obs_q.size() < 18 || obs_q[17].data !== 64'h00000000000F0000) begin
            n_fail++; $display("[TB] FAIL abc256_w17: got %h, expected 00000000000f0000", obs_q[17].data);
        end
        n_assert++;
        if (err_pulses !== 0) begin n_fail++; $display("[TB] FAIL abc256_err: got %0d pulses, expected 0", err_pulses); end
        for (int k = 0; k < 64; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL abc256_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
        n_assert++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL abc256_idle: got %0d, expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_sha512_abc();
        beat_t o, e;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = '0;
        msg[0] = 64'h6162638000000000; msg[15] = 64'h18;
        start_msg(2'b11);
        push_expected(1'b1, 1'b1);
        send_block(1'b1, 0, 80, -1);
        n_assert++;
        if (got_cnt !== 80) begin n_fail++; $display("[TB] FAIL abc512_count: got %0d, expected 80", got_cnt); end
        n_assert++;
        if (obs_q.size() < 18 || obs_q[16].data !== 64'h6162638000000000) begin
            n_fail++; $display("[TB] FAIL abc512_w16: got %h, expected 6162638000000000", obs_q[16].data);
        end
        n_assert++;
        if (obs_q.size() < 18 || obs_q[17].data !== 64'h00030000000000C0) begin
            n_fail++; $display("[TB] FAIL abc512_w17: got %h, expected 00030000000000c0", obs_q[17].data);
        end
        for (int k = 0; k < 80; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL abc512_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
        n_assert++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL abc512_idle: got %0d, expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_two_block();
        beat_t o, e;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = {$urandom, $urandom};
        start_msg(2'b01);
        push_expected(1'b0, 1'b0);
        send_block(1'b0, 0, 64, -1);
        n_assert++;
        if (dut.state !== LOAD) begin n_fail++; $display("[TB] FAIL two_block_reload: got %0d, expected %0d", dut.state, LOAD); end
        foreach (msg[k]) msg[k] = '0;
        msg[0] = 64'h61626380; msg[15] = 64'h18;
        push_expected(1'b0, 1'b1);
        send_block(1'b1, 0, 64, -1);
        for (int k = 0; k < 128; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL two_block_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
        n_assert++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL two_block_idle: got %0d, expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_backpressure();
        beat_t o, e;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = '0;
        msg[0] = 64'h6162638000000000; msg[15] = 64'h18;
        start_msg(2'b11);
        push_expected(1'b1, 1'b1);
        send_block(1'b1, 50, 80, -1);
        n_assert++;
        if (stall_events == 0) begin n_fail++; $display("[TB] FAIL bp_stalls: got 0 stalls, expected some"); end
        n_assert++;
        if (stall_changes !== 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d changes while stalled, expected 0", stall_changes); end
        for (int k = 0; k < 80; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL bp_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
    endtask

    task automatic test_mode_flip();
        beat_t o, e;
        int    extra;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = {$urandom, $urandom};
        start_msg(2'b01);
        push_expected(1'b0, 1'b1);
        send_block(1'b1, 0, 30, -1);
        sha_type = 2'b11;
        @(negedge axi_aclk);
        n_assert++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL flip_valid: got %b, expected 0", m_axis_tvalid); end
        @(negedge axi_aclk);
        n_assert++;
        if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL flip_err: got %b, expected 1", err); end
        n_assert++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL flip_idle: got %0d, expected %0d", dut.state, IDLE); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_aclk);
            if (c == 0) begin
                n_assert++;
                if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL flip_err_pulse: got %b, expected 0", err); end
            end
            if (m_axis_tvalid) extra++;
        end
        n_assert++;
        if (extra !== 0) begin n_fail++; $display("[TB] FAIL flip_silent: got %0d valid cycles, expected 0", extra); end
        for (int k = 0; k < 30; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL flip_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete();
        @(posedge axi_aclk); #1;
        sha_type = 2'b01;
    endtask

    task automatic test_tlast_err_reset();
        beat_t o, e;
        int    extra;
        obs_q.delete(); exp_q.delete();
        foreach (msg[k]) msg[k] = {$urandom, $urandom};
        start_msg(2'b01);
        push_expected(1'b0, 1'b1);
        send_block(1'b1, 0, 20, 5);
        n_assert++;
        if (err_pulses !== 1 || err_first_got !== 6) begin
            n_fail++; $display("[TB] FAIL tlast_err: got %0d pulses after word %0d, expected 1 after word 6", err_pulses, err_first_got);
        end
        for (int k = 0; k < 20; k++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '0;
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("[TB] FAIL tlast_w%0d: got %h/%0b, expected %h/%0b", k, o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete();
        reset = 1'b1;
        @(negedge axi_aclk);
        n_assert++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b0) begin
            n_fail++; $display("[TB] FAIL midreset_outputs: got %b, expected 000", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
        end
        @(posedge axi_aclk); #1;
        @(posedge axi_aclk); #1;
        reset = 1'b0;
        @(negedge axi_aclk);
        n_assert++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, err, m_axis_tdata} !== 68'd0) begin
            n_fail++; $display("[TB] FAIL after_reset_outputs: got %b/%b/%b/%b/%h, expected all 0",
                               s_axis_tready, m_axis_tvalid, m_axis_tlast, err, m_axis_tdata);
        end
        n_assert++;
        if (dut.state !== IDLE || dut.t !== 7'd0 || dut.window[15] !== 64'd0) begin
            n_fail++; $display("[TB] FAIL after_reset_state: got state %0d t %0d win15 %h, expected IDLE 0 0",
                               dut.state, dut.t, dut.window[15]);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_aclk);
            if (m_axis_tvalid) extra++;
        end
        n_assert++;
        if (extra !== 0) begin n_fail++; $display("[TB] FAIL after_reset_silent: got %0d valid cycles, expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_sha256_abc();
        test_sha512_abc();
        test_two_block();
        test_backpressure();
        test_mode_flip();
        test_tlast_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
